// File: rtl/uart_chan_router.sv
// N-channel UART line router: connects one UART core to one of NCH external links,
// with rx synchronisers, registered outputs and idle-gated channel switching.
module uart_chan_router #(
  parameter int NCH      = 2,
  parameter int SEL_W    = 1,
  parameter int IDLE_CYC = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] sel,
  input  logic             tx,
  output logic             rx,
  input  logic [NCH-1:0]   ch_rx,
  output logic [NCH-1:0]   ch_tx,
  output logic [SEL_W-1:0] active,
  output logic             switching
);

  localparam int CNT_W = $clog2(IDLE_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IDLE_CYC - 1);
  localparam logic [SEL_W:0]   NCH_V   = (SEL_W + 1)'(NCH);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_SWAP} state_t;

  state_t           state_q, state_d;
  logic [NCH-1:0]   sync1_q, sync1_d;
  logic [NCH-1:0]   s_rx_q, s_rx_d;
  logic             rx_q, rx_d;
  logic [NCH-1:0]   ch_tx_q, ch_tx_d;
  logic [SEL_W-1:0] active_q, active_d;
  logic [SEL_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             switching_q, switching_d;

  logic             rx_route;
  logic [NCH-1:0]   ch_tx_route;
  logic [SEL_W-1:0] req;
  logic             line_idle;

  // Only the active channel carries tx; every other link is parked idle-high.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_tx_route
    assign ch_tx_route[gi] = (active_q == SEL_W'(gi)) ? tx : 1'b1;
  end

  always_comb begin
    rx_route = 1'b1;
    for (int k = 0; k < NCH; k++) begin
      if (active_q == SEL_W'(k)) rx_route = s_rx_q[k];
    end
  end

  // An out-of-range request behaves as if the current channel were requested.
  assign req       = ({1'b0, sel} < NCH_V) ? sel : active_q;
  assign line_idle = tx & rx_route;
  assign sync1_d   = ch_rx;
  assign s_rx_d    = sync1_q;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    rx_d     = rx_route;
    ch_tx_d  = ch_tx_route;
    case (state_q)
      ST_RUN: begin
        if (req != active_q) begin
          target_d = req;
          cnt_d    = '0;
          state_d  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (req == active_q) begin
          state_d = ST_RUN;
        end else begin
          target_d = req;
          if (!line_idle) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = ST_SWAP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_SWAP: begin
        rx_d     = 1'b1;
        ch_tx_d  = '1;
        active_d = target_q;
        state_d  = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    switching_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      sync1_q     <= '1;
      s_rx_q      <= '1;
      rx_q        <= 1'b1;
      ch_tx_q     <= '1;
      active_q    <= '0;
      target_q    <= '0;
      cnt_q       <= '0;
      switching_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      s_rx_q      <= s_rx_d;
      rx_q        <= rx_d;
      ch_tx_q     <= ch_tx_d;
      active_q    <= active_d;
      target_q    <= target_d;
      cnt_q       <= cnt_d;
      switching_q <= switching_d;
    end
  end

  assign rx        = rx_q;
  assign ch_tx     = ch_tx_q;
  assign active    = active_q;
  assign switching = switching_q;

endmodule

// File: tb/tb_uart_chan_router.sv
// Directed bench for uart_chan_router: a 4-channel instance for routing and switching,
// a 3-channel instance for out-of-range requests and reset during a drain.
module tb_uart_chan_router;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, tx, rx, switching;
  logic [1:0] sel, active;
  logic [3:0] ch_rx, ch_tx;

  logic       rst_n_b, tx_b, rx_b, switching_b;
  logic [1:0] sel_b, active_b;
  logic [2:0] ch_rx_b, ch_tx_b;

  int checks = 0;
  int failures = 0;

  uart_chan_router #(.NCH(4), .SEL_W(2), .IDLE_CYC(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .sel(sel), .tx(tx), .rx(rx),
    .ch_rx(ch_rx), .ch_tx(ch_tx), .active(active), .switching(switching)
  );

  uart_chan_router #(.NCH(3), .SEL_W(2), .IDLE_CYC(8)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .sel(sel_b), .tx(tx_b), .rx(rx_b),
    .ch_rx(ch_rx_b), .ch_tx(ch_tx_b), .active(active_b), .switching(switching_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s got=%0h t=%0t", tag, got, $time);
    end
  endtask

  task automatic send_bit(input logic b);
    tx = b;
    tick();
    chk("busy_ch_tx", 32'(ch_tx), 32'({3'b111, b}));
    chk("busy_hold", 32'({switching, active}), 32'({1'b1, 2'd0}));
  endtask

  logic [9:0] frame;

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; rst_n_b = 1'b0;
    sel = 2'd0; sel_b = 2'd0;
    tx = 1'b1; tx_b = 1'b1;
    ch_rx = 4'b0000; ch_rx_b = 3'b111;
    repeat (3) tick();
    chk("rst_rx", 32'(rx), 32'd1);
    chk("rst_ch_tx", 32'(ch_tx), 32'hF);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_switching", 32'(switching), 32'd0);
    chk("rst_b_ch_tx", 32'(ch_tx_b), 32'h7);

    // ch_rx is low through reset; rx must fall exactly 3 cycles after release
    rst_n = 1'b1; rst_n_b = 1'b1;
    tick(); chk("sync_lat1", 32'(rx), 32'd1);
    tick(); chk("sync_lat2", 32'(rx), 32'd1);
    tick(); chk("sync_lat3", 32'(rx), 32'd0);

    ch_rx = 4'b1011;
    repeat (3) tick();
    chk("rx_ch0_high", 32'(rx), 32'd1);
    tx = 1'b1; tick(); chk("route_tx1", 32'(ch_tx), 32'hF);
    tx = 1'b0; tick(); chk("route_tx0", 32'(ch_tx), 32'hE);
    tx = 1'b1; tick(); chk("route_tx1b", 32'(ch_tx), 32'hF);
    repeat (2) tick();
    chk("rx_ignores_ch2", 32'(rx), 32'd1);
    ch_rx = 4'hF;
    repeat (3) tick();

    // idle switch 0 -> 2
    sel = 2'd2;
    tick();
    chk("sw_start", 32'({switching, active}), 32'({1'b1, 2'd0}));
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("sw_drain", 32'({switching, active}), 32'({1'b1, 2'd0}));
    end
    tick();
    chk("sw_done", 32'({switching, active}), 32'({1'b0, 2'd2}));
    chk("sw_idle_tx", 32'(ch_tx), 32'hF);
    chk("sw_idle_rx", 32'(rx), 32'd1);
    tx = 1'b0; tick();
    chk("route_ch2", 32'(ch_tx), 32'hB);
    tx = 1'b1;
    ch_rx = 4'b1011;
    repeat (3) tick();
    chk("rx_from_ch2", 32'(rx), 32'd0);
    ch_rx = 4'hF;
    repeat (3) tick();

    sel = 2'd0;
    repeat (10) tick();
    chk("back_to_0", 32'({switching, active}), 32'({1'b0, 2'd0}));

    // busy line: frames 0x55 with 5-cycle idle gaps; the switch must wait
    sel = 2'd1;
    frame = {1'b1, 8'h55, 1'b0};
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 10; i++) send_bit(frame[i]);
      if (f < 2) begin
        for (int i = 0; i < 4; i++) send_bit(1'b1);
      end
    end
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    tick();
    chk("busy_done", 32'({switching, active}), 32'({1'b0, 2'd1}));
    chk("busy_idle_tx", 32'(ch_tx), 32'hF);

    // abort: request 3, then return to the active channel
    sel = 2'd3;
    tick(); chk("abort_start", 32'({switching, active}), 32'({1'b1, 2'd1}));
    repeat (2) tick();
    chk("abort_drain", 32'({switching, active}), 32'({1'b1, 2'd1}));
    sel = 2'd1;
    tick(); chk("abort_run", 32'({switching, active}), 32'({1'b0, 2'd1}));
    repeat (10) tick();
    chk("abort_stable", 32'({switching, active}), 32'({1'b0, 2'd1}));

    // retarget 1 -> 0 -> 2; idle count carries across the retarget
    sel = 2'd0;
    tick(); chk("retgt_start", 32'(switching), 32'd1);
    repeat (2) tick();
    sel = 2'd2;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("retgt_drain", 32'({switching, active}), 32'({1'b1, 2'd1}));
    end
    tick();
    chk("retgt_done", 32'({switching, active}), 32'({1'b0, 2'd2}));

    // three-channel instance: sel=3 is out of range
    sel_b = 2'd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("oor_ignored", 32'({switching_b, active_b}), 32'({1'b0, 2'd0}));
    end
    sel_b = 2'd2;
    tick(); chk("b_drain", 32'(switching_b), 32'd1);
    tx_b = 1'b0;
    tick(); chk("b_drain_route", 32'(ch_tx_b), 32'h6);
    repeat (2) tick();
    rst_n_b = 1'b0;
    tick();
    chk("b_rst_state", 32'({switching_b, active_b}), 32'({1'b0, 2'd0}));
    chk("b_rst_ch_tx", 32'(ch_tx_b), 32'h7);
    chk("b_rst_rx", 32'(rx_b), 32'd1);
    sel_b = 2'd0; tx_b = 1'b1; rst_n_b = 1'b1;
    tick();
    chk("b_after_rst", 32'({switching_b, active_b}), 32'({1'b0, 2'd0}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
